// File: rtl/eth_avalon_rx_packer.sv
// Receive byte-to-word packer: packs MAC bytes little-endian into 36-bit FIFO
// words and appends one status word per frame; FIFO-full truncates the frame.
module eth_avalon_rx_packer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_sop_i,
  input  logic        rx_eop_i,
  input  logic        rx_err_i,
  input  logic        fifo_wrfull_i,
  output logic [35:0] fifo_data_o,
  output logic        fifo_wrreq_o,
  output logic [15:0] drop_count_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, PACK, DROP, STAT} state_t;

  state_t             state_q, state_d;
  logic [1:0]         lane_q, lane_d;
  logic [31:0]        word_q, word_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               err_q, err_d;
  logic               ovr_q, ovr_d;
  logic               lost_q, lost_d;
  logic               pend_q, pend_d;
  logic               done_q, done_d;
  logic [35:0]        data_q, data_d;
  logic [15:0]        drop_q, drop_d;

  logic [31:0]        assembled_s;
  logic [LEN_W-1:0]   len_inc_s;
  logic               wfail_s;

  function automatic logic [35:0] stat_word(input logic [LEN_W-1:0] len,
                                            input logic err, input logic ovr);
    logic too_long;
    logic runt;
    too_long = (len > LEN_W'(MAX_LEN));
    runt     = (len < LEN_W'(MIN_LEN));
    return {2'b11, 2'b00, 16'(len), 12'h000, too_long, ovr, err, runt};
  endfunction

  // Next-state logic for packing, frame bookkeeping and status sequencing
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    word_d  = word_q;
    len_d   = len_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    lost_d  = lost_q;
    pend_d  = 1'b0;
    done_d  = done_q;
    data_d  = data_q;
    drop_d  = drop_q;

    assembled_s = word_q | (32'(rx_data_i) << {lane_q, 3'b000});
    len_inc_s   = (&len_q) ? len_q : len_q + LEN_W'(1);
    // A pending word that meets a full FIFO in its write cycle is lost for good
    wfail_s     = pend_q & fifo_wrfull_i;
    if (wfail_s) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = ovr_q;
    end

    case (state_q)
      IDLE: begin
        if (rx_valid_i && rx_sop_i) begin
          len_d  = LEN_W'(1);
          err_d  = rx_err_i;
          ovr_d  = 1'b0;
          done_d = 1'b0;
          lost_d = 1'b0;
          if (rx_eop_i) begin
            data_d  = {1'b0, 1'b1, 2'b00, 24'h000000, rx_data_i};
            pend_d  = 1'b1;
            word_d  = 32'h0;
            lane_d  = 2'd0;
            state_d = STAT;
          end else begin
            word_d  = 32'(rx_data_i);
            lane_d  = 2'd1;
            state_d = PACK;
          end
        end else begin
          state_d = IDLE;
        end
      end
      PACK: begin
        if (rx_valid_i && rx_sop_i) begin
          err_d   = 1'b1;
          drop_d  = drop_q + 16'd1;
          lost_d  = ~rx_eop_i;
          word_d  = 32'h0;
          lane_d  = 2'd0;
          state_d = STAT;
          if (lane_q != 2'd0) begin
            data_d = {1'b0, 1'b1, lane_q - 2'd1, word_q};
            pend_d = 1'b1;
          end else begin
            pend_d = 1'b0;
          end
        end else if (rx_valid_i) begin
          len_d = len_inc_s;
          err_d = err_q | rx_err_i;
          if (wfail_s) begin
            word_d  = 32'h0;
            lane_d  = 2'd0;
            state_d = rx_eop_i ? STAT : DROP;
          end else if (rx_eop_i || lane_q == 2'd3) begin
            data_d  = {1'b0, rx_eop_i, lane_q, assembled_s};
            pend_d  = 1'b1;
            word_d  = 32'h0;
            lane_d  = 2'd0;
            state_d = rx_eop_i ? STAT : PACK;
          end else begin
            word_d = assembled_s;
            lane_d = lane_q + 2'd1;
          end
        end else if (wfail_s) begin
          word_d  = 32'h0;
          lane_d  = 2'd0;
          state_d = DROP;
        end else begin
          state_d = PACK;
        end
      end
      DROP: begin
        if (rx_valid_i && rx_sop_i) begin
          err_d   = 1'b1;
          drop_d  = drop_q + 16'd1;
          lost_d  = ~rx_eop_i;
          state_d = STAT;
        end else if (rx_valid_i) begin
          len_d   = len_inc_s;
          err_d   = err_q | rx_err_i;
          state_d = rx_eop_i ? STAT : DROP;
        end else begin
          state_d = DROP;
        end
      end
      STAT: begin
        if (rx_valid_i && rx_sop_i) begin
          drop_d = drop_q + 16'd1;
          lost_d = ~rx_eop_i;
        end else if (rx_valid_i && rx_eop_i) begin
          lost_d = 1'b0;
        end else begin
          lost_d = lost_q;
        end
        if (!pend_q && !done_q && !fifo_wrfull_i) begin
          done_d = 1'b1;
        end else begin
          done_d = done_q;
        end
        if (done_d && !lost_d) begin
          state_d = IDLE;
        end else begin
          state_d = STAT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status word is staged one cycle ahead so it can go out right after the last data write
    if (state_d == STAT && !pend_d && !done_d) begin
      data_d = stat_word(len_d, err_d, ovr_d);
    end else begin
      data_d = data_d;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q  <= 2'd0;
      word_q  <= 32'h0;
      len_q   <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      lost_q  <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= 36'h0;
      drop_q  <= 16'h0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      len_q   <= len_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      lost_q  <= lost_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign fifo_wrreq_o = ~reset & ~fifo_wrfull_i & (pend_q | (state_q == STAT && !done_q));
  assign fifo_data_o  = data_q;
  assign drop_count_o = drop_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_eth_avalon_rx_packer.sv
// Directed bench for eth_avalon_rx_packer: captures every FIFO write and checks
// words against hand-computed values per scenario.
module tb_eth_avalon_rx_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_sop = 1'b0;
  logic        rx_eop = 1'b0;
  logic        rx_err = 1'b0;
  logic        fifo_wrfull = 1'b0;
  logic [35:0] fifo_data;
  logic        fifo_wrreq;
  logic [15:0] drop_count;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;
  logic [35:0] cap_q[$];

  eth_avalon_rx_packer dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid_i   (rx_valid),
    .rx_data_i    (rx_data),
    .rx_sop_i     (rx_sop),
    .rx_eop_i     (rx_eop),
    .rx_err_i     (rx_err),
    .fifo_wrfull_i(fifo_wrfull),
    .fifo_data_o  (fifo_data),
    .fifo_wrreq_o (fifo_wrreq),
    .drop_count_o (drop_count),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_wrreq) cap_q.push_back(fifo_data);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // byte i carries value i; wrfull high for byte indices full_lo..full_hi
  task automatic send_frame(input int len, input int err_idx, input int full_lo,
                            input int full_hi, input int rst_idx, input bit last_eop);
    for (int i = 0; i < len; i++) begin
      rx_valid    = 1'b1;
      rx_data     = 8'(i);
      rx_sop      = (i == 0);
      rx_eop      = last_eop && (i == len - 1);
      rx_err      = (i == err_idx);
      fifo_wrfull = (i >= full_lo) && (i <= full_hi);
      reset       = (i == rst_idx);
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_err = 1'b0;
    fifo_wrfull = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(2);
    n_checks++; if (fifo_wrreq !== 1'b0) begin n_fail++; $display("FAIL reset_wrreq got %b want 0", fifo_wrreq); end
    n_checks++; if (fifo_data !== 36'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", fifo_data); end
    n_checks++; if (drop_count !== 16'h0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_full_frame;
    logic [35:0] exp;
    cap_q.delete();
    send_frame(64, -1, -1, -1, -1, 1'b1);
    idle(4);
    n_checks++; if (cap_q.size() !== 17) begin n_fail++; $display("FAIL full_count got %0d want 17", cap_q.size()); end
    if (cap_q.size() == 17) begin
      n_checks++; if (cap_q[0] !== 36'h3_0302_0100) begin n_fail++; $display("FAIL full_first got %h want 303020100", cap_q[0]); end
      n_checks++; if (cap_q[15] !== 36'h7_3F3E_3D3C) begin n_fail++; $display("FAIL full_last got %h want 73f3e3d3c", cap_q[15]); end
      n_checks++; if (cap_q[16] !== 36'hC_0040_0000) begin n_fail++; $display("FAIL full_status got %h want c00400000", cap_q[16]); end
      for (int k = 0; k < 16; k++) begin
        exp = {1'b0, (k == 15), 2'b11, 8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
        n_checks++; if (cap_q[k] !== exp) begin n_fail++; $display("FAIL full_word%0d got %h want %h", k, cap_q[k], exp); end
      end
    end
  endtask

  task automatic test_runt;
    cap_q.delete();
    send_frame(61, -1, -1, -1, -1, 1'b1);
    idle(4);
    n_checks++; if (cap_q.size() !== 17) begin n_fail++; $display("FAIL runt_count got %0d want 17", cap_q.size()); end
    if (cap_q.size() == 17) begin
      n_checks++; if (cap_q[14] !== 36'h3_3B3A_3938) begin n_fail++; $display("FAIL runt_word14 got %h want 33b3a3938", cap_q[14]); end
      n_checks++; if (cap_q[15] !== 36'h4_0000_003C) begin n_fail++; $display("FAIL runt_last got %h want 40000003c", cap_q[15]); end
      n_checks++; if (cap_q[16] !== 36'hC_003D_0001) begin n_fail++; $display("FAIL runt_status got %h want c003d0001", cap_q[16]); end
    end
  endtask

  task automatic test_overrun;
    int ndata;
    cap_q.delete();
    send_frame(100, -1, 40, 80, -1, 1'b1);
    idle(4);
    ndata = 0;
    foreach (cap_q[k]) if (cap_q[k][35] == 1'b0) ndata++;
    n_checks++; if (cap_q.size() !== 10) begin n_fail++; $display("FAIL ovr_count got %0d want 10", cap_q.size()); end
    n_checks++; if (ndata !== 9) begin n_fail++; $display("FAIL ovr_data_words got %0d want 9", ndata); end
    if (cap_q.size() == 10) begin
      n_checks++; if (cap_q[8] !== 36'h3_2322_2120) begin n_fail++; $display("FAIL ovr_word8 got %h want 323222120", cap_q[8]); end
      n_checks++; if (cap_q[9] !== 36'hC_0064_0004) begin n_fail++; $display("FAIL ovr_status got %h want c00640004", cap_q[9]); end
    end
  endtask

  task automatic test_err;
    cap_q.delete();
    send_frame(64, 10, -1, -1, -1, 1'b1);
    idle(4);
    n_checks++; if (cap_q.size() !== 17) begin n_fail++; $display("FAIL err_count got %0d want 17", cap_q.size()); end
    if (cap_q.size() == 17) begin
      n_checks++; if (cap_q[2] !== 36'h3_0B0A_0908) begin n_fail++; $display("FAIL err_word2 got %h want 30b0a0908", cap_q[2]); end
      n_checks++; if (cap_q[16] !== 36'hC_0040_0002) begin n_fail++; $display("FAIL err_status got %h want c00400002", cap_q[16]); end
    end
  endtask

  task automatic test_stat_hold;
    cap_q.delete();
    send_frame(64, -1, -1, -1, -1, 1'b1);
    idle(1);
    fifo_wrfull = 1'b1;
    idle(5);
    n_checks++; if (cap_q.size() !== 16) begin n_fail++; $display("FAIL hold_pending_count got %0d want 16", cap_q.size()); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy_pending got %b want 1", busy); end
    send_frame(64, -1, 0, 44, -1, 1'b1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_busy_after got %b want 0", busy); end
    idle(3);
    n_checks++; if (cap_q.size() !== 17) begin n_fail++; $display("FAIL hold_count got %0d want 17", cap_q.size()); end
    if (cap_q.size() == 17) begin
      n_checks++; if (cap_q[16] !== 36'hC_0040_0000) begin n_fail++; $display("FAIL hold_status got %h want c00400000", cap_q[16]); end
    end
    n_checks++; if (drop_count !== 16'd1) begin n_fail++; $display("FAIL hold_drop got %0d want 1", drop_count); end
  endtask

  task automatic test_sop_abort;
    cap_q.delete();
    send_frame(6, -1, -1, -1, -1, 1'b0);
    send_frame(3, -1, -1, -1, -1, 1'b1);
    idle(4);
    n_checks++; if (cap_q.size() !== 3) begin n_fail++; $display("FAIL abort_count got %0d want 3", cap_q.size()); end
    if (cap_q.size() == 3) begin
      n_checks++; if (cap_q[0] !== 36'h3_0302_0100) begin n_fail++; $display("FAIL abort_word0 got %h want 303020100", cap_q[0]); end
      n_checks++; if (cap_q[1] !== 36'h5_0000_0504) begin n_fail++; $display("FAIL abort_partial got %h want 500000504", cap_q[1]); end
      n_checks++; if (cap_q[2] !== 36'hC_0006_0003) begin n_fail++; $display("FAIL abort_status got %h want c00060003", cap_q[2]); end
    end
    n_checks++; if (drop_count !== 16'd2) begin n_fail++; $display("FAIL abort_drop got %0d want 2", drop_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    cap_q.delete();
    send_frame(64, -1, -1, -1, 20, 1'b1);
    idle(4);
    n_checks++; if (cap_q.size() !== 4) begin n_fail++; $display("FAIL rstmid_count got %0d want 4", cap_q.size()); end
    n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL rstmid_drop got %0d want 0", drop_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    cap_q.delete();
    send_frame(64, -1, -1, -1, -1, 1'b1);
    idle(4);
    n_checks++; if (cap_q.size() !== 17) begin n_fail++; $display("FAIL rstmid_next_count got %0d want 17", cap_q.size()); end
    if (cap_q.size() == 17) begin
      n_checks++; if (cap_q[0] !== 36'h3_0302_0100) begin n_fail++; $display("FAIL rstmid_first got %h want 303020100", cap_q[0]); end
      n_checks++; if (cap_q[15] !== 36'h7_3F3E_3D3C) begin n_fail++; $display("FAIL rstmid_last got %h want 73f3e3d3c", cap_q[15]); end
      n_checks++; if (cap_q[16] !== 36'hC_0040_0000) begin n_fail++; $display("FAIL rstmid_status got %h want c00400000", cap_q[16]); end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_runt();
    test_overrun();
    test_err();
    test_stat_hold();
    test_sop_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
